// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding and baud divisor.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Truncating divide; callers guarantee the result is at least 2.
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side write port of the buffered UART: store strobe and byte in, FIFO status out.
interface uart_tx_buffered_if #(
   parameter int unsigned DEPTH_LOG2 = 4
) ();

   logic                uart_enablen;
   logic [7:0]          data;
   logic                uart_busy;
   logic                overflow;
   logic [DEPTH_LOG2:0] fifo_count;

   modport master (
      output uart_enablen, data,
      input  uart_busy, overflow, fifo_count
   );

   modport slave (
      input  uart_enablen, data,
      output uart_busy, overflow, fifo_count
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head is read straight from the storage registers.
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  sysclk,
   input  logic                  cpu_resetn,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic [WIDTH-1:0]      head
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push, do_pop;

   // Both decisions use the registered count, so a same-cycle pop never frees a slot.
   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign head    = mem_q[rptr_q];

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge sysclk) begin
      if (do_push) mem_q[wptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by CPU stores; never stalls, drops and flags on overflow.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic              sysclk,
   input  logic              cpu_resetn,
   uart_tx_buffered_if.slave wr,
   output logic              tx_active,
   output logic              uart_tx
);

   localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_head;
   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             ovf_q;
   logic             wrap;

   assign fifo_push = ~wr.uart_enablen;

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .push       (fifo_push),
      .push_data  (wr.data),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (wr.fifo_count),
      .head       (fifo_head)
   );

`ifdef UART_TX_PARITY_EN
   logic par_q;

   // Parity is captured at load because the shifter is consumed during DATA.
   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn)   par_q <= 1'b0;
      else if (fifo_pop) par_q <= ^fifo_head;
   end
`endif

   assign wrap = (cnt_q == CNT_MAX);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      if (state_q != ST_IDLE) cnt_d = wrap ? '0 : cnt_q + 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_head;
               tx_d     = 1'b0;
               cnt_d    = '0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (wrap) begin
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (wrap) begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (wrap) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (wrap) begin
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_head;
                  tx_d     = 1'b0;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (fifo_push && fifo_full) ovf_q <= 1'b1;
      end
   end

   assign wr.uart_busy = fifo_full;
   assign wr.overflow  = ovf_q;
   assign tx_active    = (state_q != ST_IDLE);
   assign uart_tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a timing-level reference queue predicts each frame,
// a line decoder pops and compares. Honours UART_TX_PARITY_EN for frame length and parity.
module tb_uart_tx_buffered;

   localparam int unsigned CLK_HZ     = 1000000;
   localparam int unsigned BAUD       = 100000;
   localparam int unsigned DIV        = CLK_HZ / BAUD;
   localparam int unsigned DEPTH_LOG2 = 4;
   localparam int unsigned DEPTH      = 16;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * DIV;

   logic sysclk     = 1'b0;
   logic cpu_resetn = 1'b1;
   logic tx_active;
   logic uart_tx;

   uart_tx_buffered_if #(.DEPTH_LOG2(DEPTH_LOG2)) u_if ();

   uart_tx_buffered #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .wr         (u_if),
      .tx_active  (tx_active),
      .uart_tx    (uart_tx)
   );

   always #5 sysclk = ~sysclk;

   int unsigned cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  b;
      int unsigned c;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  m_q[$];
   bit          m_active = 1'b0;
   bit          m_ovf    = 1'b0;
   int unsigned m_end    = 0;
   int unsigned rst_epoch = 0;
   int unsigned peak     = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a frame occupies FRAME cycles; the queue is popped when idle or at frame end.
   initial begin : ref_model
      bit   do_pop, wr_ok;
      exp_t e;
      forever begin
         @(posedge sysclk);
         if (cpu_resetn) begin
            do_pop = (m_q.size() > 0) && (!m_active || cyc == m_end);
            wr_ok  = (m_q.size() < DEPTH);
            if (!do_pop && m_active && cyc == m_end) m_active = 1'b0;
            if (do_pop) begin
               e.b = m_q.pop_front();
               e.c = cyc + 1;
               sb.push_back(e);
               m_active = 1'b1;
               m_end    = cyc + FRAME;
            end
            if (!u_if.uart_enablen) begin
               if (wr_ok) m_q.push_back(u_if.data);
               else       m_ovf = 1'b1;
            end
         end
      end
   end

   initial begin : status_checker
      forever begin
         @(negedge sysclk);
         check("fifo_count", 32'(u_if.fifo_count), 32'(m_q.size()));
         check("uart_busy", 32'(u_if.uart_busy), 32'(m_q.size() == DEPTH));
         check("overflow", 32'(u_if.overflow), 32'(m_ovf));
         check("tx_active", 32'(tx_active), 32'(m_active));
         if (u_if.fifo_count > peak) peak = u_if.fifo_count;
      end
   end

   initial begin : line_monitor
      int unsigned ep, start_c, b;
      logic [7:0]  got;
      logic        st_bit, sp_bit, par_bit;
      bit          ok;
      exp_t        e;
      forever begin
         @(negedge sysclk);
         if (cpu_resetn && uart_tx == 1'b0) begin
            ep = rst_epoch; start_c = cyc; ok = 1'b1;
            got = '0; st_bit = 1'b1; sp_bit = 1'b0; par_bit = 1'b0;
            for (int j = 0; j < int'(FRAME); j++) begin
               if (j > 0) @(negedge sysclk);
               if (rst_epoch != ep) begin
                  ok = 1'b0;
                  break;
               end
               if (j % DIV == DIV / 2) begin
                  b = j / DIV;
                  if (b == 0)                 st_bit = uart_tx;
                  else if (b <= 8)            got[b-1] = uart_tx;
                  else if (b == NBITS - 1)    sp_bit = uart_tx;
                  else                        par_bit = uart_tx;
               end
            end
            if (ok) begin
               if (sb.size() == 0) begin
                  check("unexpected frame", 32'(got), 32'h100);
               end else begin
                  e = sb.pop_front();
                  check("frame byte", 32'(got), 32'(e.b));
                  check("frame start cycle", start_c, e.c);
                  check("start bit", 32'(st_bit), 32'd0);
                  check("stop bit", 32'(sp_bit), 32'd1);
`ifdef UART_TX_PARITY_EN
                  check("parity bit", 32'(par_bit), 32'(^e.b));
`endif
               end
            end
         end
      end
   end

   task automatic wr(input logic [7:0] b);
      u_if.uart_enablen = 1'b0;
      u_if.data         = b;
      @(negedge sysclk);
   endtask

   task automatic idle(input int unsigned n);
      u_if.uart_enablen = 1'b1;
      repeat (n) @(negedge sysclk);
   endtask

   task automatic drain();
      bit done = 1'b0;
      u_if.uart_enablen = 1'b1;
      for (int k = 0; k < 6000; k++) begin
         if (sb.size() == 0 && m_q.size() == 0 && !m_active) begin
            done = 1'b1;
            break;
         end
         @(negedge sysclk);
      end
      check("drain completes", 32'(done), 32'd1);
      check("scoreboard empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin : stimulus
      int unsigned lows;
      bit          found;
      u_if.uart_enablen = 1'b1;
      u_if.data         = '0;
      #1 cpu_resetn = 1'b0;
      #1;
      check("reset uart_tx", 32'(uart_tx), 32'd1);
      check("reset uart_busy", 32'(u_if.uart_busy), 32'd0);
      check("reset tx_active", 32'(tx_active), 32'd0);
      check("reset fifo_count", 32'(u_if.fifo_count), 32'd0);
      check("reset overflow", 32'(u_if.overflow), 32'd0);
      repeat (3) @(negedge sysclk);
      cpu_resetn = 1'b1;
      idle(5);

      // Single byte from idle.
      wr(8'hA5);
      idle(FRAME + 20);

      // Three consecutive writes: one is popped immediately, so occupancy peaks at 2.
      peak = 0;
      wr(8'h11); wr(8'h22); wr(8'h33);
      idle(5);
      check("t2 peak fifo_count", peak, 32'd2);
      idle(3 * FRAME + 20);

      // Sustained writes overrun the FIFO.
      peak = 0;
      for (int i = 0; i < 20; i++) wr(8'(i));
      idle(1);
      check("t3 peak fifo_count", peak, 32'd16);
      check("t3 overflow", 32'(u_if.overflow), 32'd1);
      drain();

      // Reset in the middle of a data bit with bytes queued.
      wr(8'h5A); wr(8'h01); wr(8'h02); wr(8'h03);
      idle(40);
      check("t4 queued before reset", 32'(u_if.fifo_count), 32'd3);
      #2;
      cpu_resetn = 1'b0;
      rst_epoch++;
      m_q.delete();
      sb.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      #1;
      check("t4 uart_tx in reset", 32'(uart_tx), 32'd1);
      check("t4 fifo_count in reset", 32'(u_if.fifo_count), 32'd0);
      check("t4 overflow in reset", 32'(u_if.overflow), 32'd0);
      repeat (2) @(negedge sysclk);
      cpu_resetn = 1'b1;
      lows = 0;
      repeat (3 * FRAME) begin
         @(negedge sysclk);
         if (!uart_tx) lows++;
      end
      check("t4 line low cycles after reset", lows, 32'd0);

      // Write on the stop-end edge that pops from a full FIFO.
      for (int i = 0; i < 17; i++) wr(8'(8'h80 + i));
      idle(1);
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (cyc == m_end) begin
            found = 1'b1;
            break;
         end
         @(negedge sysclk);
      end
      check("t5 stop end reached", 32'(found), 32'd1);
      check("t5 count before", 32'(u_if.fifo_count), 32'd16);
      check("t5 overflow before", 32'(u_if.overflow), 32'd0);
      wr(8'hEE);
      check("t5 count after", 32'(u_if.fifo_count), 32'd15);
      check("t5 overflow after", 32'(u_if.overflow), 32'd1);
      drain();

      // Randomised bursts and gaps.
      for (int i = 0; i < 30; i++) begin
         int unsigned n;
         n = $urandom_range(1, 4);
         for (int j = 0; j < int'(n); j++) wr(8'($urandom));
         idle($urandom_range(0, 150));
      end
      drain();

      // Odd and even parity bytes.
      wr(8'h07);
      idle(FRAME + 5);
      wr(8'h03);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
